ysyx_22051013_lsu: RTL and testbench

- Memory-access stage of the 5-stage RV64 pipeline, between EXU and the write-back stage.
- Takes the EXU result (an ALU value or an effective address) and runs loads and stores on a variable-latency data-memory bus with valid/ready handshakes.
- Sign- or zero-extends load data.
- Presents one registered result per instruction to write-back, plus a forwarding tap for IDU.

---
 rtl/ysyx_22051013_lsu_pkg.sv | 44 ++++
 rtl/ysyx_22051013_lsu_align.sv | 36 +++
 rtl/ysyx_22051013_lsu.sv | 224 ++++++++++++++++++++++
 tb/tb_ysyx_22051013_lsu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared LSU definitions: widths, funct3 memory codes, write-back selectors and FSM states.
package ysyx_22051013_lsu_pkg;

    localparam int unsigned LSU_DATA_W    = 64;
    localparam int unsigned LSU_PC_W      = 64;
    localparam int unsigned LSU_INST_W    = 32;
    localparam int unsigned LSU_REGADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_ALU  = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_WAIT = 2'b10
    } lsu_state_e;

    // Byte-enable pattern for an access size at offset 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case ({1'b0, sz})
            F3_SB:   m = 8'h01;
            F3_SH:   m = 8'h03;
            F3_SW:   m = 8'h0F;
            F3_SD:   m = 8'hFF;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// Combinational byte-lane alignment: store mask/data placement and load shift with extension.
module ysyx_22051013_lsu_align
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic [2:0]        off_i,
    input  logic [2:0]        mem_op_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [7:0]        wmask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [DATA_W-1:0] raw;

    always_comb begin
        // Bytes shifted past lane 7 fall off; misalignment is silently truncated.
        wmask_o = size_mask(mem_op_i[1:0]) << off_i;
        wdata_o = st_data_i << {off_i, 3'b000};
        raw     = rdata_i >> {off_i, 3'b000};

        case (mem_op_i)
            F3_LB:   ld_data_o = {{(DATA_W-8){raw[7]}}, raw[7:0]};
            F3_LH:   ld_data_o = {{(DATA_W-16){raw[15]}}, raw[15:0]};
            F3_LW:   ld_data_o = {{(DATA_W-32){raw[31]}}, raw[31:0]};
            F3_LD:   ld_data_o = raw;
            F3_LBU:  ld_data_o = {{(DATA_W-8){1'b0}}, raw[7:0]};
            F3_LHU:  ld_data_o = {{(DATA_W-16){1'b0}}, raw[15:0]};
            F3_LWU:  ld_data_o = {{(DATA_W-32){1'b0}}, raw[31:0]};
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Memory-access stage: request register + IDLE/REQ/WAIT bus FSM feeding an independent output register.
module ysyx_22051013_lsu
    import ysyx_22051013_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = LSU_DATA_W,
    parameter int unsigned REG_AW = LSU_REGADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ls_ready,
    input  logic [LSU_PC_W-1:0]   ex_pc,
    input  logic [LSU_INST_W-1:0] ex_inst,
    input  logic [DATA_W-1:0]     exu_res_i,
    input  logic [DATA_W-1:0]     st_data,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [2:0]            mem_op,
    input  logic [1:0]            wb_ctl_i,
    input  logic                  rd_ena_i,
    input  logic [REG_AW-1:0]     rd_addr_i,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic                  dmem_wen,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic [7:0]            dmem_wmask,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  ls_valid,
    input  logic                  wb_ready,
    output logic [DATA_W-1:0]     ls_rd_data,
    output logic [DATA_W-1:0]     exu_res_o,
    output logic [1:0]            wb_ctl_o,
    output logic [LSU_PC_W-1:0]   pc_o,
    output logic [LSU_INST_W-1:0] inst_o,
    output logic                  rd_ena_o,
    output logic [REG_AW-1:0]     rd_addr_o,
    output logic                  ls_fwd_valid,
    output logic [REG_AW-1:0]     ls_fwd_addr,
    output logic [DATA_W-1:0]     ls_fwd_data
);

    lsu_state_e state_q, state_d;
    logic req_valid_q, req_valid_d;

    logic [LSU_PC_W-1:0]   rq_pc_q, rq_pc_d;
    logic [LSU_INST_W-1:0] rq_inst_q, rq_inst_d;
    logic [DATA_W-1:0]     rq_res_q, rq_res_d;
    logic [DATA_W-1:0]     rq_st_q, rq_st_d;
    logic [2:0]            rq_op_q, rq_op_d;
    logic [1:0]            rq_wb_q, rq_wb_d;
    logic                  rq_rd_ena_q, rq_rd_ena_d;
    logic [REG_AW-1:0]     rq_rd_addr_q, rq_rd_addr_d;
    logic                  rq_store_q, rq_store_d;

    logic                  ls_valid_q, ls_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [DATA_W-1:0]     res_o_q, res_o_d;
    logic [1:0]            wb_o_q, wb_o_d;
    logic [LSU_PC_W-1:0]   pc_o_q, pc_o_d;
    logic [LSU_INST_W-1:0] inst_o_q, inst_o_d;
    logic                  rd_ena_o_q, rd_ena_o_d;
    logic [REG_AW-1:0]     rd_addr_o_q, rd_addr_o_d;

    logic              accept, is_mem, rsp_done;
    logic [7:0]        al_wmask;
    logic [DATA_W-1:0] al_wdata, al_ld;

    ysyx_22051013_lsu_align #(.DATA_W(DATA_W)) u_align (
        .off_i    (rq_res_q[2:0]),
        .mem_op_i (rq_op_q),
        .st_data_i(rq_st_q),
        .rdata_i  (dmem_rdata),
        .wmask_o  (al_wmask),
        .wdata_o  (al_wdata),
        .ld_data_o(al_ld)
    );

    assign ls_ready = (state_q == LSU_IDLE) && (!ls_valid_q || wb_ready);
    assign accept   = ex_valid && ls_ready;
    assign is_mem   = mem_rd || mem_wr;
    assign rsp_done = (state_q == LSU_WAIT) && dmem_rsp_valid;

    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        rq_pc_d      = rq_pc_q;
        rq_inst_d    = rq_inst_q;
        rq_res_d     = rq_res_q;
        rq_st_d      = rq_st_q;
        rq_op_d      = rq_op_q;
        rq_wb_d      = rq_wb_q;
        rq_rd_ena_d  = rq_rd_ena_q;
        rq_rd_addr_d = rq_rd_addr_q;
        rq_store_d   = rq_store_q;
        ls_valid_d   = ls_valid_q;
        rd_data_d    = rd_data_q;
        res_o_d      = res_o_q;
        wb_o_d       = wb_o_q;
        pc_o_d       = pc_o_q;
        inst_o_d     = inst_o_q;
        rd_ena_o_d   = rd_ena_o_q;
        rd_addr_o_d  = rd_addr_o_q;

        if (accept) begin
            rq_pc_d      = ex_pc;
            rq_inst_d    = ex_inst;
            rq_res_d     = exu_res_i;
            rq_st_d      = st_data;
            rq_op_d      = mem_op;
            rq_wb_d      = wb_ctl_i;
            rq_rd_ena_d  = rd_ena_i;
            rq_rd_addr_d = rd_addr_i;
            // A simultaneous rd+wr is resolved as a store.
            rq_store_d   = mem_wr;
        end

        case (state_q)
            LSU_IDLE: if (accept && is_mem) begin
                state_d     = LSU_REQ;
                req_valid_d = 1'b1;
            end
            LSU_REQ: if (dmem_req_ready) begin
                state_d     = LSU_WAIT;
                req_valid_d = 1'b0;
            end
            LSU_WAIT: if (dmem_rsp_valid) state_d = LSU_IDLE;
            default: begin
                state_d     = LSU_IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        // ALU results bypass the request register to keep single-cycle latency.
        if (accept && !is_mem) begin
            ls_valid_d  = 1'b1;
            rd_data_d   = '0;
            res_o_d     = exu_res_i;
            wb_o_d      = wb_ctl_i;
            pc_o_d      = ex_pc;
            inst_o_d    = ex_inst;
            rd_ena_o_d  = rd_ena_i;
            rd_addr_o_d = rd_addr_i;
        end else if (rsp_done) begin
            ls_valid_d  = 1'b1;
            rd_data_d   = rq_store_q ? '0 : al_ld;
            res_o_d     = rq_res_q;
            wb_o_d      = rq_wb_q;
            pc_o_d      = rq_pc_q;
            inst_o_d    = rq_inst_q;
            rd_ena_o_d  = rq_rd_ena_q;
            rd_addr_o_d = rq_rd_addr_q;
        end else if (ls_valid_q && wb_ready) begin
            ls_valid_d = 1'b0;
            inst_o_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            req_valid_q  <= 1'b0;
            rq_pc_q      <= '0;
            rq_inst_q    <= '0;
            rq_res_q     <= '0;
            rq_st_q      <= '0;
            rq_op_q      <= '0;
            rq_wb_q      <= '0;
            rq_rd_ena_q  <= 1'b0;
            rq_rd_addr_q <= '0;
            rq_store_q   <= 1'b0;
            ls_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            res_o_q      <= '0;
            wb_o_q       <= '0;
            pc_o_q       <= '0;
            inst_o_q     <= '0;
            rd_ena_o_q   <= 1'b0;
            rd_addr_o_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            rq_pc_q      <= rq_pc_d;
            rq_inst_q    <= rq_inst_d;
            rq_res_q     <= rq_res_d;
            rq_st_q      <= rq_st_d;
            rq_op_q      <= rq_op_d;
            rq_wb_q      <= rq_wb_d;
            rq_rd_ena_q  <= rq_rd_ena_d;
            rq_rd_addr_q <= rq_rd_addr_d;
            rq_store_q   <= rq_store_d;
            ls_valid_q   <= ls_valid_d;
            rd_data_q    <= rd_data_d;
            res_o_q      <= res_o_d;
            wb_o_q       <= wb_o_d;
            pc_o_q       <= pc_o_d;
            inst_o_q     <= inst_o_d;
            rd_ena_o_q   <= rd_ena_o_d;
            rd_addr_o_q  <= rd_addr_o_d;
        end
    end

    // Bus fields are driven only while a request is outstanding, so they read 0 otherwise.
    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = req_valid_q ? {rq_res_q[DATA_W-1:3], 3'b000} : '0;
    assign dmem_wen       = req_valid_q && rq_store_q;
    assign dmem_wdata     = req_valid_q ? al_wdata : '0;
    assign dmem_wmask     = req_valid_q ? al_wmask : '0;

    assign ls_valid   = ls_valid_q;
    assign ls_rd_data = rd_data_q;
    assign exu_res_o  = res_o_q;
    assign wb_ctl_o   = wb_o_q;
    assign pc_o       = pc_o_q;
    assign inst_o     = inst_o_q;
    assign rd_ena_o   = rd_ena_o_q;
    assign rd_addr_o  = rd_addr_o_q;

    assign ls_fwd_valid = ls_valid_q && rd_ena_o_q && (rd_addr_o_q != '0);
    assign ls_fwd_addr  = rd_addr_o_q;
    assign ls_fwd_data  = (wb_o_q == WB_LOAD) ? rd_data_q : res_o_q;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Directed plus randomized bench for the LSU against an arithmetic reference model.
module tb_ysyx_22051013_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ls_ready;
    logic [63:0] ex_pc;
    logic [31:0] ex_inst;
    logic [63:0] exu_res_i;
    logic [63:0] st_data;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_op;
    logic [1:0]  wb_ctl_i;
    logic        rd_ena_i;
    logic [4:0]  rd_addr_i;
    logic        dmem_req_valid, dmem_req_ready;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rdata;
    logic        ls_valid, wb_ready;
    logic [63:0] ls_rd_data, exu_res_o;
    logic [1:0]  wb_ctl_o;
    logic [63:0] pc_o;
    logic [31:0] inst_o;
    logic        rd_ena_o;
    logic [4:0]  rd_addr_o;
    logic        ls_fwd_valid;
    logic [4:0]  ls_fwd_addr;
    logic [63:0] ls_fwd_data;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [63:0] obs_addr, obs_wdata, obs_rd;
    logic [7:0]  obs_mask;

    always #5 clk = ~clk;

    ysyx_22051013_lsu #(.DATA_W(64), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ls_ready(ls_ready),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .exu_res_i(exu_res_i), .st_data(st_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op), .wb_ctl_i(wb_ctl_i),
        .rd_ena_i(rd_ena_i), .rd_addr_i(rd_addr_i),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .dmem_wmask(dmem_wmask), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .ls_valid(ls_valid), .wb_ready(wb_ready), .ls_rd_data(ls_rd_data),
        .exu_res_o(exu_res_o), .wb_ctl_o(wb_ctl_o), .pc_o(pc_o), .inst_o(inst_o),
        .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o),
        .ls_fwd_valid(ls_fwd_valid), .ls_fwd_addr(ls_fwd_addr), .ls_fwd_data(ls_fwd_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_bytes(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] op, input logic [2:0] off);
        logic [15:0] t;
        t = ((16'd1 << m_bytes(op)) - 16'd1) << off;
        return t[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] op, input logic [63:0] d,
                                           input logic [2:0] off);
        logic [63:0] raw, keep, v;
        int unsigned nb;
        nb  = m_bytes(op);
        raw = d >> (8 * off);
        if (op == 3'd7) return 64'd0;
        keep = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = raw & keep;
        if (!op[2] && nb < 8 && v[8*nb-1]) v = v | ~keep;
        return v;
    endfunction

    task automatic scramble_inputs();
        ex_pc = {$urandom, $urandom}; ex_inst = $urandom;
        exu_res_i = {$urandom, $urandom}; st_data = {$urandom, $urandom};
        mem_op = 3'($urandom); rd_addr_i = 5'($urandom);
    endtask

    // Issues one instruction at the current negedge and ends at the negedge where its result shows.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [63:0] addr, input logic [63:0] sdata, input logic [63:0] rdata,
                         input int unsigned req_wait, input int unsigned rsp_wait,
                         input logic ena, input logic [4:0] rda);
        logic [63:0] pc;
        logic [31:0] inst;
        logic [1:0]  wb;
        logic [63:0] exp_rd, exp_fwd;
        logic [2:0]  off;
        pc   = {$urandom, $urandom};
        inst = $urandom;
        wb   = rd ? 2'b01 : (wr ? 2'b00 : 2'b10);
        off  = addr[2:0];
        wb_ready = 1'b1;
        ex_valid = 1'b1; ex_pc = pc; ex_inst = inst; exu_res_i = addr; st_data = sdata;
        mem_rd = rd; mem_wr = wr; mem_op = op; wb_ctl_i = wb; rd_ena_i = ena; rd_addr_i = rda;
        #1 chk("accept_ready", {63'd0, ls_ready}, 64'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        scramble_inputs();
        if (rd || wr) begin
            for (int unsigned i = 0; ; i++) begin
                chk("req_valid", {63'd0, dmem_req_valid}, 64'd1);
                chk("req_addr", dmem_addr, {addr[63:3], 3'b000});
                chk("req_wen", {63'd0, dmem_wen}, {63'd0, wr});
                chk("req_mask", {56'd0, dmem_wmask}, {56'd0, m_mask(op, off)});
                chk("req_wdata", dmem_wdata, sdata << (8 * off));
                chk("busy_ready", {63'd0, ls_ready}, 64'd0);
                chk("busy_valid", {63'd0, ls_valid}, 64'd0);
                obs_addr = dmem_addr; obs_mask = dmem_wmask; obs_wdata = dmem_wdata;
                if (i == req_wait) break;
                @(negedge clk);
            end
            dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem_req_ready = 1'b0;
            chk("wait_req_low", {63'd0, dmem_req_valid}, 64'd0);
            repeat (rsp_wait) begin
                dmem_rdata = {$urandom, $urandom};
                @(negedge clk);
                chk("wait_valid", {63'd0, ls_valid}, 64'd0);
            end
            dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_rsp_valid = 1'b0; dmem_rdata = {$urandom, $urandom};
            exp_rd = wr ? 64'd0 : m_load(op, rdata, off);
            chk("rd_data", ls_rd_data, exp_rd);
        end else begin
            exp_rd = 64'd0;
            chk("alu_no_req", {63'd0, dmem_req_valid}, 64'd0);
        end
        obs_rd  = ls_rd_data;
        exp_fwd = (wb == 2'b01) ? exp_rd : addr;
        chk("out_valid", {63'd0, ls_valid}, 64'd1);
        chk("out_pc", pc_o, pc);
        chk("out_inst", {32'd0, inst_o}, {32'd0, inst});
        chk("out_res", exu_res_o, addr);
        chk("out_wb", {62'd0, wb_ctl_o}, {62'd0, wb});
        chk("out_rdaddr", {59'd0, rd_addr_o}, {59'd0, rda});
        chk("fwd_valid", {63'd0, ls_fwd_valid}, {63'd0, ena && rda != 5'd0});
        chk("fwd_addr", {59'd0, ls_fwd_addr}, {59'd0, rda});
        chk("fwd_data", ls_fwd_data, exp_fwd);
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        dmem_rdata = '0; wb_ready = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; wb_ctl_i = '0;
        rd_ena_i = 1'b0; scramble_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {63'd0, ls_valid}, 64'd0);
        chk("rst_req", {63'd0, dmem_req_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst_o}, 64'd0);
        chk("rst_res", exu_res_o, 64'd0);
        chk("rst_mask", {56'd0, dmem_wmask}, 64'd0);
        chk("rst_fwd", {63'd0, ls_fwd_valid}, 64'd0);
        @(negedge clk);
        chk("ready_after_rst", {63'd0, ls_ready}, 64'd1);

        // ALU pass-through with one-cycle latency
        do_op(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 64'd0, 0, 0, 1'b1, 5'd5);
        chk("alu_fwd_addr", {59'd0, ls_fwd_addr}, 64'd5);
        chk("alu_fwd_data", ls_fwd_data, 64'h1234);

        // lb / lbu of byte 3 with two response wait cycles
        do_op(1'b1, 1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 2, 1'b1, 5'd7);
        chk("lb_addr", obs_addr, 64'h8000_0000);
        chk("lb_data", obs_rd, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(1'b1, 1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 2, 1'b1, 5'd7);
        chk("lbu_data", obs_rd, 64'h80);

        // Stores at offset 6, word store loses its upper bytes
        do_op(1'b0, 1'b1, 3'b001, 64'h8000_1006, 64'hABCD, 64'd0, 0, 0, 1'b0, 5'd0);
        chk("sh_mask", {56'd0, obs_mask}, 64'hC0);
        chk("sh_wdata", obs_wdata, 64'hABCD_0000_0000_0000);
        do_op(1'b0, 1'b1, 3'b010, 64'h8000_1006, 64'h1122_3344, 64'd0, 0, 0, 1'b0, 5'd0);
        chk("sw_mask", {56'd0, obs_mask}, 64'hC0);

        // Backpressured request held for 4 cycles
        do_op(1'b1, 1'b0, 3'b011, 64'h8000_2010, 64'd0, 64'h0123_4567_89AB_CDEF, 4, 1, 1'b1, 5'd9);

        // Write-back stall: output holds, new instruction waits
        do_op(1'b0, 1'b0, 3'd0, 64'h5555, 64'd0, 64'd0, 0, 0, 1'b1, 5'd3);
        wb_ready = 1'b0;
        ex_valid = 1'b1; exu_res_i = 64'h6666; ex_inst = 32'hCAFE_0001; mem_rd = 1'b0;
        mem_wr = 1'b0; wb_ctl_i = 2'b10; rd_ena_i = 1'b1; rd_addr_i = 5'd4;
        #1 chk("stall_ready", {63'd0, ls_ready}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, ls_valid}, 64'd1);
            chk("stall_res", exu_res_o, 64'h5555);
            chk("stall_rdaddr", {59'd0, rd_addr_o}, 64'd3);
            chk("stall_ready2", {63'd0, ls_ready}, 64'd0);
        end
        wb_ready = 1'b1;
        #1 chk("release_ready", {63'd0, ls_ready}, 64'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        chk("release_valid", {63'd0, ls_valid}, 64'd1);
        chk("release_res", exu_res_o, 64'h6666);
        chk("release_inst", {32'd0, inst_o}, 64'hCAFE_0001);
        @(negedge clk);
        chk("drain_valid", {63'd0, ls_valid}, 64'd0);
        chk("drain_inst", {32'd0, inst_o}, 64'd0);

        // Reset while waiting for a load response, then a stray response
        ex_valid = 1'b1; exu_res_i = 64'h8000_3000; mem_rd = 1'b1; mem_wr = 1'b0;
        mem_op = 3'b011; wb_ctl_i = 2'b01;
        @(negedge clk);
        ex_valid = 1'b0; dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_rsp_valid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("rstw_valid", {63'd0, ls_valid}, 64'd0);
        chk("rstw_req", {63'd0, dmem_req_valid}, 64'd0);
        chk("rstw_idle", {63'd0, ls_ready}, 64'd1);
        chk("rstw_inst", {32'd0, inst_o}, 64'd0);
        chk("rstw_rd", ls_rd_data, 64'd0);
        chk("rstw_pc", pc_o, 64'd0);
        chk("rstw_addr", dmem_addr, 64'd0);

        // Randomized mix of ALU, load and store operations
        for (int k = 0; k < 40; k++) begin
            int unsigned kind;
            logic is_rd, is_wr;
            logic [2:0] op;
            kind  = $urandom_range(0, 2);
            is_rd = (kind == 1);
            is_wr = (kind == 2);
            op    = is_wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            do_op(is_rd, is_wr, op, {32'h8000_0000 + 32'($urandom_range(0, 4095)), $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
